// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- RAM BIST: FSM states, element indices and
// the per-element direction / read-expect / write-data table.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_M0,
      S_RD,
      S_WR,
      S_M5,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [2:0] EL_M0 = 3'd0;
   localparam logic [2:0] EL_M1 = 3'd1;
   localparam logic [2:0] EL_M2 = 3'd2;
   localparam logic [2:0] EL_M3 = 3'd3;
   localparam logic [2:0] EL_M4 = 3'd4;
   localparam logic [2:0] EL_M5 = 3'd5;

   typedef struct packed {
      logic down;    // address order: 1 = high to low
      logic rd_bit;  // logical value expected on read
      logic wr_bit;  // logical value written
   } elem_cfg_t;

   function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
      elem_cfg_t cfg;
      case (elem)
         EL_M0:   cfg = '{down: 1'b0, rd_bit: 1'b0, wr_bit: 1'b0};
         EL_M1:   cfg = '{down: 1'b0, rd_bit: 1'b0, wr_bit: 1'b1};
         EL_M2:   cfg = '{down: 1'b0, rd_bit: 1'b1, wr_bit: 1'b0};
         EL_M3:   cfg = '{down: 1'b1, rd_bit: 1'b0, wr_bit: 1'b1};
         EL_M4:   cfg = '{down: 1'b1, rd_bit: 1'b1, wr_bit: 1'b0};
         default: cfg = '{down: 1'b0, rd_bit: 1'b0, wr_bit: 1'b0};
      endcase
      return cfg;
   endfunction

endpackage

// File: rtl/ram_march_bist.sv
// March C- BIST controller driving a registered-read single-port RAM;
// reports pass/fail with the element, address and data of the first mismatch.
module ram_march_bist
   import ram_bist_pkg::*;
#(
   parameter int                ADDR_W = 4,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BG     = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [2:0]        fail_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   function automatic logic [DATA_W-1:0] pattern(input logic bit_val);
      return bit_val ? ~BG : BG;
   endfunction

   state_t            state, nxt_state;
   logic [2:0]        elem, nxt_elem;
   logic [ADDR_W-1:0] nxt_addr;
   logic              nxt_we, nxt_busy, nxt_done, nxt_pass;
   logic [DATA_W-1:0] nxt_wdata;
   logic [2:0]        nxt_fail_elem;
   logic [ADDR_W-1:0] nxt_fail_addr;
   logic [DATA_W-1:0] nxt_fail_data;

   elem_cfg_t         cfg, step_cfg, out_cfg;
   logic              at_end;
   logic [ADDR_W-1:0] step_addr;
   logic [DATA_W-1:0] exp_data;
   logic              cmp_en, mismatch;
   logic [ADDR_W-1:0] cmp_addr;

   // Comparator: WR cycles check the read issued one cycle earlier; in M5 the
   // read pipeline lags by one address, and FLUSH drains the last one.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cfg       = elem_cfg(elem);
      step_cfg  = elem_cfg(elem + 3'd1);
      at_end    = cfg.down ? (ram_addr == '0) : (ram_addr == '1);
      step_addr = cfg.down ? ram_addr - ADDR_W'(1) : ram_addr + ADDR_W'(1);
      exp_data  = pattern(cfg.rd_bit);
      cmp_en    = 1'b0;
      cmp_addr  = ram_addr;
      case (state)
         S_WR:    cmp_en = 1'b1;
         S_M5: begin
            cmp_en   = (ram_addr != '0);
            cmp_addr = ram_addr - ADDR_W'(1);
         end
         S_FLUSH: cmp_en = 1'b1;
         default: cmp_en = 1'b0;
      endcase
      mismatch = cmp_en && (ram_data_out != exp_data);
   end

   always_comb begin
      nxt_state     = state;
      nxt_elem      = elem;
      nxt_addr      = ram_addr;
      nxt_pass      = pass;
      nxt_fail_elem = fail_elem;
      nxt_fail_addr = fail_addr;
      nxt_fail_data = fail_data;

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               nxt_state     = S_M0;
               nxt_elem      = EL_M0;
               nxt_addr      = '0;
               nxt_pass      = 1'b0;
               nxt_fail_elem = '0;
               nxt_fail_addr = '0;
               nxt_fail_data = '0;
            end
         end
         S_M0: begin
            if (at_end) begin
               nxt_state = S_RD;
               nxt_elem  = EL_M1;
               nxt_addr  = '0;
            end else begin
               nxt_addr = step_addr;
            end
         end
         S_RD: nxt_state = S_WR;
         S_WR: begin
            if (!at_end) begin
               nxt_state = S_RD;
               nxt_addr  = step_addr;
            end else if (elem == EL_M4) begin
               nxt_state = S_M5;
               nxt_elem  = EL_M5;
               nxt_addr  = '0;
            end else begin
               nxt_state = S_RD;
               nxt_elem  = elem + 3'd1;
               nxt_addr  = step_cfg.down ? '1 : '0;
            end
         end
         S_M5: begin
            if (at_end) nxt_state = S_FLUSH;
            else        nxt_addr  = step_addr;
         end
         S_FLUSH: begin
            nxt_state = S_DONE;
            nxt_addr  = '0;
            nxt_pass  = 1'b1;
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_addr  = '0;
         end
      endcase

      // First mismatch wins: the remaining elements are abandoned.
      if (mismatch) begin
         nxt_state     = S_DONE;
         nxt_addr      = '0;
         nxt_pass      = 1'b0;
         nxt_fail_elem = elem;
         nxt_fail_addr = cmp_addr;
         nxt_fail_data = ram_data_out;
      end

      out_cfg   = elem_cfg(nxt_elem);
      nxt_we    = (nxt_state == S_M0) || (nxt_state == S_WR);
      nxt_wdata = nxt_we ? pattern(out_cfg.wr_bit) : '0;
      nxt_busy  = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      nxt_done  = (nxt_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state       <= S_IDLE;
         elem        <= EL_M0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_elem   <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_data_in <= '0;
      end else begin
         state       <= nxt_state;
         elem        <= nxt_elem;
         busy        <= nxt_busy;
         done        <= nxt_done;
         pass        <= nxt_pass;
         fail_elem   <= nxt_fail_elem;
         fail_addr   <= nxt_fail_addr;
         fail_data   <= nxt_fail_data;
         ram_we      <= nxt_we;
         ram_addr    <= nxt_addr;
         ram_data_in <= nxt_wdata;
      end
   end

endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist: two instances (BG=00 with fault-injectable
// RAM model, BG=55 clean) and directed runs with hand-derived completion cycles.
module tb_ram_march_bist;

   typedef struct {
      int         cyc;
      logic       pass;
      logic [2:0] elem;
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: BG = 8'h00
   logic       start_a, busy_a, done_a, pass_a, we_a;
   logic [2:0] felem_a;
   logic [3:0] faddr_a, addr_a;
   logic [7:0] fdata_a, din_a, dout_a;
   // Instance B: BG = 8'h55
   logic       start_b, busy_b, done_b, pass_b, we_b;
   logic [2:0] felem_b;
   logic [3:0] faddr_b, addr_b;
   logic [7:0] fdata_b, din_b, dout_b;

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];
   logic       sa_en, cf_en, clr;

   ram_march_bist #(.ADDR_W(4), .DATA_W(8), .BG(8'h00)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_elem(felem_a), .fail_addr(faddr_a), .fail_data(fdata_a),
      .ram_we(we_a), .ram_addr(addr_a), .ram_data_in(din_a), .ram_data_out(dout_a)
   );

   ram_march_bist #(.ADDR_W(4), .DATA_W(8), .BG(8'h55)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_elem(felem_b), .fail_addr(faddr_b), .fail_data(fdata_b),
      .ram_we(we_b), .ram_addr(addr_b), .ram_data_in(din_b), .ram_data_out(dout_b)
   );

   // RAM A: stuck-at-1 on bit 3 of word 5; a 0->1 write on bit 0 of word 9 sets bit 0 of word 8.
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= 8'h00;
      end else if (we_a) begin
         mem_a[addr_a] <= (sa_en && addr_a == 4'd5) ? (din_a | 8'h08) : din_a;
         if (cf_en && addr_a == 4'd9 && !mem_a[9][0] && din_a[0]) mem_a[8][0] <= 1'b1;
      end
      dout_a <= (sa_en && addr_a == 4'd5) ? (mem_a[addr_a] | 8'h08) : mem_a[addr_a];
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= 8'h00;
      end else if (we_b) begin
         mem_b[addr_b] <= din_b;
      end
      dout_b <= mem_b[addr_b];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_compare(input string tag, input exp_t e, input logic busy,
                             input logic pass, input logic [2:0] fe,
                             input logic [3:0] fa, input logic [7:0] fd);
      check({tag, "_done_cycle"}, cyc, e.cyc);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_pass"}, pass, e.pass);
      check({tag, "_fail_elem"}, fe, e.elem);
      check({tag, "_fail_addr"}, fa, e.addr);
      check({tag, "_fail_data"}, fd, e.data);
   endtask

   // Scoreboard monitors: compare on each rising edge of done.
   exp_t q_a[$];
   exp_t q_b[$];
   logic done_q_a, done_q_b;

   always @(negedge clk) begin
      if (rst) begin
         done_q_a <= 1'b0;
      end else begin
         if (done_a && !done_q_a) begin
            if (q_a.size() == 0) check("a_unexpected_done", done_a, 1'b0);
            else sb_compare("a", q_a.pop_front(), busy_a, pass_a, felem_a, faddr_a, fdata_a);
         end
         done_q_a <= done_a;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         done_q_b <= 1'b0;
      end else begin
         if (done_b && !done_q_b) begin
            if (q_b.size() == 0) check("b_unexpected_done", done_b, 1'b0);
            else sb_compare("b", q_b.pop_front(), busy_b, pass_b, felem_b, faddr_b, fdata_b);
         end
         done_q_b <= done_b;
      end
   end

   task automatic push_a(input int c, input logic p, input logic [2:0] e,
                         input logic [3:0] a, input logic [7:0] d);
      exp_t x;
      x.cyc = c; x.pass = p; x.elem = e; x.addr = a; x.data = d;
      q_a.push_back(x);
   endtask

   task automatic pulse_start_a(output int n);
      @(negedge clk);
      start_a = 1'b1;
      n = cyc;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic pulse_start_b(output int n);
      @(negedge clk);
      start_b = 1'b1;
      n = cyc;
      @(negedge clk);
      start_b = 1'b0;
   endtask

   task automatic clear_rams();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_done_a(input string name);
      int budget = 400;
      while (!done_a && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check(name, done_a, 1'b1);
   endtask

   task automatic no_writes_a(input string name);
      int w = 0;
      for (int i = 0; i < 8; i++) begin
         if (we_a) w++;
         @(negedge clk);
      end
      check(name, w, 0);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_busy"}, busy_a, 1'b0);
      check({tag, "_done"}, done_a, 1'b0);
      check({tag, "_pass"}, pass_a, 1'b0);
      check({tag, "_fail_elem"}, felem_a, 3'd0);
      check({tag, "_fail_addr"}, faddr_a, 4'd0);
      check({tag, "_fail_data"}, fdata_a, 8'h00);
      check({tag, "_we"}, we_a, 1'b0);
      check({tag, "_addr"}, addr_a, 4'd0);
      check({tag, "_din"}, din_a, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bad, budget;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      sa_en = 1'b0; cf_en = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_a("rst");
      check("rst_b_busy", busy_b, 1'b0);
      check("rst_b_we", we_b, 1'b0);
      rst = 1'b0;

      // Clean run, BG=00
      clear_rams();
      pulse_start_a(n);
      push_a(n + 162, 1'b1, 3'd0, 4'd0, 8'h00);
      check("clean_m0_busy", busy_a, 1'b1);
      check("clean_m0_we", we_a, 1'b1);
      check("clean_m0_addr", addr_a, 4'd0);
      check("clean_m0_din", din_a, 8'h00);
      wait_cyc(n + 161);
      check("clean_flush_busy", busy_a, 1'b1);
      check("clean_flush_done", done_a, 1'b0);
      wait_done_a("clean_done_seen");
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_a[i] !== 8'h00) bad++;
      check("clean_final_mem_bad_words", bad, 0);

      // Restart from DONE, with an ignored start during M2
      pulse_start_a(n);
      push_a(n + 162, 1'b1, 3'd0, 4'd0, 8'h00);
      check("restart_done_cleared", done_a, 1'b0);
      check("restart_busy", busy_a, 1'b1);
      wait_cyc(n + 60);
      pulse_start_a(bad);
      wait_done_a("restart_done_seen");

      // Stuck-at-1 on bit 3 of address 5
      sa_en = 1'b1;
      clear_rams();
      pulse_start_a(n);
      push_a(n + 29, 1'b0, 3'd1, 4'd5, 8'h08);
      wait_done_a("sa_done_seen");
      no_writes_a("sa_we_after_done");

      // Coupling fault 9 -> 8
      sa_en = 1'b0;
      cf_en = 1'b1;
      clear_rams();
      pulse_start_a(n);
      push_a(n + 97, 1'b0, 3'd3, 4'd8, 8'h01);
      wait_done_a("cf_done_seen");
      no_writes_a("cf_we_after_done");

      // Reset during M3, then a fresh clean run
      cf_en = 1'b0;
      pulse_start_a(n);
      wait_cyc(n + 90);
      check("m3_busy_before_rst", busy_a, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_a("m3rst");
      rst = 1'b0;
      pulse_start_a(n);
      push_a(n + 162, 1'b1, 3'd0, 4'd0, 8'h00);
      wait_done_a("post_rst_done_seen");

      // Instance B: BG=55
      clear_rams();
      pulse_start_b(n);
      begin
         exp_t x;
         x.cyc = n + 162; x.pass = 1'b1; x.elem = 3'd0; x.addr = 4'd0; x.data = 8'h00;
         q_b.push_back(x);
      end
      check("bg55_m0_din", din_b, 8'h55);
      wait_cyc(n + 18);
      check("bg55_m1_wr_we", we_b, 1'b1);
      check("bg55_m1_wr_din", din_b, 8'hAA);
      budget = 400;
      while (!done_b && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("bg55_done_seen", done_b, 1'b1);
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem_b[i] !== 8'h55) bad++;
      check("bg55_final_mem_bad_words", bad, 0);

      repeat (2) @(negedge clk);
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
